// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - word RAM with burst load port and registered fetch port
// Define INSTR_MEM_FWD_EN to forward a same-cycle load beat onto a matching fetch.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_all,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  busy,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  beat;
  logic [DATA_WIDTH-1:0] rd_word;

  assign beat = load_valid && (state_q == LOAD);

  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    load_ready = 1'b0;
    load_done  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          ptr_d   = load_base;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (beat) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          if (load_last) state_d = DONE;
        end
      end
      DONE: begin
        load_done = 1'b1;
        busy      = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory is flop-based so that reset can clear every word without a clock.
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (beat) begin
      mem[ptr_q] <= load_data;
    end
  end

`ifdef INSTR_MEM_FWD_EN
  assign rd_word = (beat && (ptr_q == fetch_addr)) ? load_data : mem[fetch_addr];
`else
  assign rd_word = mem[fetch_addr];
`endif

  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetch_req;
      if (fetch_req) fetch_data <= rd_word;
    end
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Parametrised successor to the fixed 128x32 instruction memory.
- Word-addressed RAM with configurable width and depth.
- Burst program-load port: FSM, auto-incrementing write pointer, ready/valid handshake.
- Registered fetch port with a valid strobe, 1-cycle latency. Sits between the boot/test loader and the CPU fetch stage.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 7, word address width; DEPTH = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, rising-edge
rst_all  input  1  asynchronous active-low reset
load_start  input  1  pulse in IDLE: begin burst at load_base
load_base  input  ADDR_WIDTH  first word address of burst
load_valid  input  1  load_data holds a valid word
load_last  input  1  qualifies final beat of burst
load_data  input  DATA_WIDTH  word to write
load_ready  output  1  memory accepts a beat this cycle
load_done  output  1  one-cycle pulse after final beat written
busy  output  1  FSM not in IDLE
fetch_req  input  1  read request
fetch_addr  input  ADDR_WIDTH  word address to read
fetch_valid  output  1  fetch_data valid (1 cycle after accepted req)
fetch_data  output  DATA_WIDTH  read word

Behaviour:
- Reset (rst_all=0, asynchronous, no clock needed):
  - every memory word = 0; state = IDLE; write pointer = 0
  - load_ready=0, load_done=0, busy=0, fetch_valid=0, fetch_data=0
- Reset mid-burst: the burst is abandoned; no partial state is retained.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: load_ready=0. load_start=1 -> pointer <= load_base, go to LOAD. load_start outside IDLE is ignored.
  - LOAD: load_ready=1, busy=1. Beat = load_valid & load_ready: mem[pointer] <= load_data, pointer <= pointer+1.
  - Beat with load_last=1 -> DONE. load_last without load_valid is ignored. No beat -> stay in LOAD, pointer unchanged.
  - DONE: load_ready=0, load_done=1 for exactly this one cycle, busy=1; next cycle IDLE.
- Pointer wrap: modulo DEPTH; a beat at DEPTH-1 writes the last word, next beat writes address 0. No error flag.
- Fetch:
  - Accepted in every state, every cycle; no backpressure.
  - fetch_req=1 at edge N -> fetch_valid=1 and fetch_data=mem[fetch_addr] after edge N+1 (registered, 1-cycle latency).
  - fetch_req=0 -> fetch_valid=0 next cycle; fetch_data holds its last value.
  - Back-to-back requests give one result per cycle.
- Same-cycle fetch and load beat to the same address: read-before-write, so fetch_data returns the old word (unless the feature below is enabled). Different addresses: independent.
- Widths: all address arithmetic is ADDR_WIDTH bits, unsigned, truncating.

Optional Feature:
INSTR_MEM_FWD_EN
- Defined: a same-cycle fetch/beat address match returns the new load_data on fetch_data (write-through forwarding).
- Undefined: read-before-write, returns the old word.
- Everything else is identical.

Test Plan:
- Reset: hold rst_all=0 mid-cycle, then release; fetch addrs 0, 64, 127 -> fetch_valid=1 one cycle after each req, fetch_data=0x00000000; busy=0.
- Burst: load_start with load_base=10; 4 beats 0xA0000001..0xA0000004, last on 4th -> load_done pulses 1 cycle; fetch 10..13 returns those words; fetch 14 returns 0.
- Stalls and wrap: load_base=126; beats 0x11,0x22,0x33 with load_valid=0 gaps between them -> mem[126]=0x11, mem[127]=0x22, mem[0]=0x33; load_ready=1 throughout LOAD.
- Collision: during LOAD, fetch addr 20 while beat writes 0xDEADBEEF to 20, old value 0x5 -> fetch_data=0x5 (0xDEADBEEF with INSTR_MEM_FWD_EN); later fetch -> 0xDEADBEEF.
- Reset mid-burst: assert rst_all after 2 of 5 beats -> state IDLE, both written words read back 0, load_done never pulses.
- Ignored start: load_start during LOAD with load_base=99 -> pointer unaffected; the burst continues at its original addresses.
